// File: rtl/regfile_pkg.sv
// Shared types and defaults for the banked register file and its dump engine.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 1;
  localparam int unsigned DEF_INT_REGS   = 8;
  localparam int unsigned DEF_EXT_REGS   = 4;
  localparam int unsigned DEF_BYPASS     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } dump_state_e;

  // True when addr falls in the writable internal bank.
  function automatic logic is_int_addr(input int unsigned addr, input int unsigned int_regs);
    return addr < int_regs;
  endfunction

endpackage

// File: rtl/regfile_banked_if.sv
// Register-file bus: write port, two read ports, external capture, dump stream.
interface regfile_banked_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned INT_REGS_No = DEF_INT_REGS,
  parameter int unsigned EXT_REGS_No = DEF_EXT_REGS
);
  localparam int unsigned ADDR_WIDTH = $clog2(INT_REGS_No + EXT_REGS_No);

  logic                              wr;
  logic [ADDR_WIDTH-1:0]             wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic [ADDR_WIDTH-1:0]             rd_addr_a;
  logic [ADDR_WIDTH-1:0]             rd_addr_b;
  logic [DATA_WIDTH-1:0]             rd_data_a;
  logic [DATA_WIDTH-1:0]             rd_data_b;
  logic [EXT_REGS_No*DATA_WIDTH-1:0] ext_in;
  logic                              ext_sample;
  logic [INT_REGS_No*DATA_WIDTH-1:0] int_regs_out;
  logic                              wr_err;
  logic                              dump_req;
  logic                              dump_valid;
  logic                              dump_ready;
  logic [DATA_WIDTH-1:0]             dump_data;
  logic [ADDR_WIDTH-1:0]             dump_idx;
  logic                              dump_last;
  logic                              dump_busy;

  modport master (
    output wr, wr_addr, wr_data, rd_addr_a, rd_addr_b, ext_in, ext_sample,
           dump_req, dump_ready,
    input  rd_data_a, rd_data_b, int_regs_out, wr_err, dump_valid, dump_data,
           dump_idx, dump_last, dump_busy
  );

  modport slave (
    input  wr, wr_addr, wr_data, rd_addr_a, rd_addr_b, ext_in, ext_sample,
           dump_req, dump_ready,
    output rd_data_a, rd_data_b, int_regs_out, wr_err, dump_valid, dump_data,
           dump_idx, dump_last, dump_busy
  );

endinterface

// File: rtl/rf_dump_fsm.sv
// Dump engine: walks the internal bank index by index over a valid/ready stream.
module rf_dump_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned INT_REGS_No = DEF_INT_REGS,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_req,
  input  logic                  dump_ready,
  input  logic [DATA_WIDTH-1:0] bank_data,
  output logic [ADDR_WIDTH-1:0] bank_idx,
  output logic                  dump_valid,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_idx,
  output logic                  dump_last,
  output logic                  dump_busy
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INT_REGS_No - 1);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;

  // Next state; flag outputs are decoded from the next state so they land registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:  if (dump_req) state_d = START;
      START: begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bank_idx   = idx_q;
  assign dump_idx   = idx_q;
  assign dump_data  = bank_data;
  assign dump_valid = valid_q;
  assign dump_last  = last_q;
  assign dump_busy  = busy_q;

endmodule

// File: rtl/regfile_banked.sv
// Banked register file: internal writable bank, captured external bank, two read ports, dump.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned INT_REGS_No = DEF_INT_REGS,
  parameter int unsigned EXT_REGS_No = DEF_EXT_REGS,
  parameter int unsigned BYPASS      = DEF_BYPASS
) (
  input logic             clk,
  input logic             rst,
  regfile_banked_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(INT_REGS_No + EXT_REGS_No);
  localparam int unsigned INT_BITS   = INT_REGS_No * DATA_WIDTH;
  localparam int unsigned EXT_BITS   = EXT_REGS_No * DATA_WIDTH;
  localparam logic        BYP_EN     = (BYPASS != 0);

  logic [INT_BITS-1:0]   mem_q, mem_d;
  logic [EXT_BITS-1:0]   ext_q, ext_d;
  logic                  wr_err_q, wr_err_d;
  logic                  wr_legal_c;
  logic [ADDR_WIDTH-1:0] dump_idx_c;
  logic [DATA_WIDTH-1:0] dump_rd_c;

  // Flat address map lookup; unmapped addresses read as zero.
  function automatic logic [DATA_WIDTH-1:0] read_reg(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [INT_BITS-1:0]   mem,
    input logic [EXT_BITS-1:0]   ext
  );
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    for (int unsigned i = 0; i < INT_REGS_No; i++)
      if (addr == ADDR_WIDTH'(i)) data = mem[i*DATA_WIDTH +: DATA_WIDTH];
    for (int unsigned k = 0; k < EXT_REGS_No; k++)
      if (addr == ADDR_WIDTH'(INT_REGS_No + k)) data = ext[k*DATA_WIDTH +: DATA_WIDTH];
    return data;
  endfunction

  assign wr_legal_c = bus.wr && is_int_addr(32'(bus.wr_addr), INT_REGS_No);

  always_comb begin
    mem_d    = mem_q;
    ext_d    = ext_q;
    wr_err_d = bus.wr && !wr_legal_c;
    for (int unsigned i = 0; i < INT_REGS_No; i++)
      if (wr_legal_c && (bus.wr_addr == ADDR_WIDTH'(i)))
        mem_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
    if (bus.ext_sample) ext_d = bus.ext_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      ext_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      ext_q    <= ext_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Read ports; the bypass only forwards writes that will actually land.
  assign bus.rd_data_a = (BYP_EN && wr_legal_c && (bus.rd_addr_a == bus.wr_addr))
                         ? bus.wr_data : read_reg(bus.rd_addr_a, mem_q, ext_q);
  assign bus.rd_data_b = (BYP_EN && wr_legal_c && (bus.rd_addr_b == bus.wr_addr))
                         ? bus.wr_data : read_reg(bus.rd_addr_b, mem_q, ext_q);

  assign bus.int_regs_out = mem_q;
  assign bus.wr_err       = wr_err_q;
  assign dump_rd_c        = read_reg(dump_idx_c, mem_q, ext_q);

  rf_dump_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .INT_REGS_No(INT_REGS_No),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (bus.dump_req),
    .dump_ready(bus.dump_ready),
    .bank_data (dump_rd_c),
    .bank_idx  (dump_idx_c),
    .dump_valid(bus.dump_valid),
    .dump_data (bus.dump_data),
    .dump_idx  (bus.dump_idx),
    .dump_last (bus.dump_last),
    .dump_busy (bus.dump_busy)
  );

endmodule

// File: doc/regfile_banked.md
# regfile_banked

Parametrised register file for the 1-bit CPU, the successor to the fixed 2+2 register block. It provides a flat address map over writable internal registers and read-only external (captured input) registers, with two combinational read ports, an optional write-to-read bypass, illegal-write flagging and a serial dump engine. The dump engine streams the internal bank to the debug/semaphore side over a valid/ready handshake. The block sits between the control unit and the ALU operand muxes.

## Interface
- DATA_WIDTH, 1: bits per register
- INT_REGS_No, 8: internal (writable) registers, ≥2
- EXT_REGS_No, 4: external (read-only) registers, ≥1
- BYPASS, 1: 1 = read ports see same-cycle write data
- ADDR_WIDTH (derived localparam): $clog2(INT_REGS_No+EXT_REGS_No)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_addr_a / rd_addr_b  in  ADDR_WIDTH  read addresses
- rd_data_a / rd_data_b  out  DATA_WIDTH  read data, combinational
- ext_in  in  EXT_REGS_No*DATA_WIDTH  external inputs, packed, register k at [k*DW +: DW]
- ext_sample  in  1  capture ext_in into the external bank
- int_regs_out  out  INT_REGS_No*DATA_WIDTH  packed internal bank contents
- wr_err  out  1  registered pulse: previous-cycle write was illegal
- dump_req  in  1  start a dump
- dump_valid  out  1  dump_data/dump_idx valid
- dump_ready  in  1  consumer accepts
- dump_data  out  DATA_WIDTH  dumped register value
- dump_idx  out  ADDR_WIDTH  index of dumped register
- dump_last  out  1  current beat is index INT_REGS_No-1
- dump_busy  out  1  dump engine not idle

## Operation
- Address map: 0..INT-1 internal; INT..INT+EXT-1 external; above that, unmapped. Unmapped reads return 0.
- Write: when wr=1 and wr_addr<INT, mem[wr_addr] takes wr_data at the clock edge.
- Writes with wr_addr≥INT are dropped and wr_err=1 for exactly one cycle. Back-to-back illegal writes hold wr_err high.
- External bank: when ext_sample=1, all EXT registers load ext_in at the edge. Otherwise they hold.
- Bypass (BYPASS=1): if wr=1, the write is legal and rd_addr_x==wr_addr, then rd_data_x=wr_data. BYPASS=0 returns the stored value.
- Dump FSM states:
  - IDLE→START on dump_req.
  - START→SEND with idx=0.
  - In SEND, each valid&ready increments idx. On the last beat, SEND→IDLE.
  - dump_busy=1 in START and SEND. dump_valid=1 only in SEND.
  - dump_req is ignored while busy.
- dump_data is the live stored value mem[dump_idx], never bypassed. A write to the current index shows up after its edge.
- dump_idx/dump_data are held stable while dump_valid=1 and dump_ready=0.
- Writes and ext_sample proceed normally during a dump.

## Timing
- Reset (asserted): all registers 0. FSM IDLE. wr_err, dump_valid, dump_busy, dump_last = 0. dump_idx = 0.
- Reset mid-dump aborts immediately. No resume.
- Write-to-read latency: 0 cycles with BYPASS, 1 cycle without.
- ext_sample-to-read latency: 1 cycle.
- dump_req at edge n: busy at n+1, first valid at n+2.
- With ready held high, one beat per cycle. A full dump takes INT_REGS_No+1 cycles after the request edge.
- busy falls the cycle after the last handshake. A new dump_req is accepted that same cycle.

## Structure
- Shared `regfile_pkg` holds:
  - dump state enum {IDLE, START, SEND}
  - the default parameter constants
  - function `is_int_addr`
- Sub-module `rf_dump_fsm` contains the state, index counter and handshake. It reads the bank through an index/data pair.
- Storage, write decode, bypass and read muxes stay in the top module.

## Test plan
- Reset → write 1 to regs 0..7 (DW=1) → int_regs_out=8'hFF. Assert rst low → all outputs 0 asynchronously.
- wr=1, wr_addr=9, wr_data=1 → no register changes; wr_err=1 next cycle only. wr_addr=12 (unmapped) read → rd_data=0.
- BYPASS=1: wr reg3←1 while rd_addr_a=3 → rd_data_a=1 in the same cycle. BYPASS=0: rd_data_a=0, then 1 the next cycle.
- ext_in=4'b1010, ext_sample=1 → reads of addr 8..11 return 0,1,0,1 from the next cycle. Change ext_in with ext_sample=0 → reads unchanged.
- Bank=8'b1100_1010, dump_req, ready=1 → 8 beats idx 0..7, data 0,1,0,1,0,0,1,1, dump_last on idx 7, busy drops after.
- Dump with ready toggling 1-0-1, reg2 written mid-dump before its beat → data held while ready=0, new reg2 value dumped. rst low at idx 4 → valid/busy 0 at once.
